// File: rtl/gray_pkg.sv
// Shared constants, state encoding and luma helper for the gray conversion blocks.
package gray_pkg;

    localparam int R_COEFF = 30;
    localparam int G_COEFF = 59;
    localparam int B_COEFF = 11;
    localparam int SHIFT   = 7;
    localparam int SUM_W   = 15;   // 255*(30+59+11) = 25500 fits in 15 bits

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Weighted sum then shift; the top coefficient sum keeps the result <= 199.
    function automatic logic [7:0] luma(input logic [7:0] r,
                                        input logic [7:0] g,
                                        input logic [7:0] b);
        logic [SUM_W-1:0] sum;
        sum = SUM_W'(R_COEFF) * SUM_W'(r)
            + SUM_W'(G_COEFF) * SUM_W'(g)
            + SUM_W'(B_COEFF) * SUM_W'(b);
        return 8'(sum >> SHIFT);
    endfunction

endpackage

// File: rtl/rgb_to_gray_pipe.sv
// One registered stage of RGB-to-luma conversion with a valid and a last sideband.
module rgb_to_gray_pipe
    import gray_pkg::*;
(
    input  logic       clk,
    input  logic       rstn,
    input  logic       flush,
    input  logic       in_valid,
    input  logic       in_last,
    input  logic [7:0] in_r,
    input  logic [7:0] in_g,
    input  logic [7:0] in_b,
    output logic       out_valid,
    output logic       out_last,
    output logic [7:0] out_gray
);

    // Register the luma result; flush drops whatever is entering the stage.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_gray  <= '0;
        end else begin
            out_valid <= in_valid & ~flush;
            out_last  <= in_last;
            out_gray  <= luma(in_r, in_g, in_b);
        end
    end

endmodule

// File: rtl/gray_frame_ctrl.sv
// Frame sequencer: issues ROM reads under a credit limit, converts returns to
// gray and delivers them through a small first-word-fall-through FIFO.
module gray_frame_ctrl
    import gray_pkg::*;
#(
    parameter int H          = 391,
    parameter int W          = 317,
    parameter int ROM_LAT    = 1,
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_W     = 32
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start,
    input  logic              abort,
    output logic              rom_en,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [7:0]        rgb_red,
    input  logic [7:0]        rgb_green,
    input  logic [7:0]        rgb_blue,
    output logic              pix_valid,
    output logic [7:0]        pix_data,
    output logic              pix_last,
    input  logic              pix_ready,
    output logic              busy,
    output logic              done
);

    localparam int N      = H * W;
    localparam int CNT_W  = $clog2(N + 1);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int OUT_W  = $clog2(FIFO_DEPTH + ROM_LAT + 2);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N - 1);
    localparam logic [CNT_W-1:0]  LAST_IDX  = CNT_W'(N - 1);

    state_t                          state, state_nxt;
    logic [ROM_LAT-1:0]              vld_pipe;
    logic [CNT_W-1:0]                ret_idx;
    logic                            gp_vld, gp_last;
    logic [7:0]                      gp_gray;
    logic [FIFO_DEPTH-1:0][8:0]      fifo_mem;
    logic [PTR_W-1:0]                wr_ptr, rd_ptr;
    logic [PTR_W:0]                  fifo_cnt;
    logic [OUT_W-1:0]                outstanding;
    logic                            issue, frame_start, fifo_empty;
    logic                            pop, fifo_push, fifo_pop;
    logic [8:0]                      head;

    assign frame_start = (state == IDLE || state == DONE) & start & ~abort;
    assign fifo_empty  = (fifo_cnt == '0);

    // Reads not yet accepted downstream: ROM pipe, luma stage and FIFO.
    always_comb begin
        outstanding = OUT_W'(fifo_cnt) + OUT_W'(gp_vld);
        for (int i = 0; i < ROM_LAT; i++)
            outstanding = outstanding + OUT_W'(vld_pipe[i]);
    end

    assign issue = (state == RUN) && (outstanding < OUT_W'(FIFO_DEPTH));

    // The luma stage output bypasses an empty FIFO so the first pixel appears
    // ROM_LAT+1 cycles after its read; otherwise the oldest entry is shown.
    assign head      = fifo_empty ? {gp_last, gp_gray} : fifo_mem[rd_ptr];
    assign pix_valid = gp_vld | ~fifo_empty;
    assign pix_data  = head[7:0];
    assign pix_last  = pix_valid & head[8];
    assign pop       = pix_valid & pix_ready;
    assign fifo_push = gp_vld & ~(pop & fifo_empty);
    assign fifo_pop  = pop & ~fifo_empty;

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic; abort overrides everything.
    always_comb begin
        state_nxt = state;
        if (abort) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE, DONE: if (start)                          state_nxt = RUN;
                RUN:        if (issue && rom_addr == LAST_ADDR) state_nxt = DRAIN;
                DRAIN:      if (pop && pix_last)                state_nxt = DONE;
                default:                                        state_nxt = IDLE;
            endcase
        end
    end

    // Status and read strobe decoded from state.
    always_comb begin
        busy   = (state == RUN) || (state == DRAIN);
        done   = (state == DONE);
        rom_en = issue;
    end

    // Read address: restarts at zero each frame, parks on the last pixel.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)                                rom_addr <= '0;
        else if (abort || frame_start)            rom_addr <= '0;
        else if (issue && rom_addr != LAST_ADDR)  rom_addr <= rom_addr + ADDR_W'(1);
    end

    // In-flight read tracker, one bit per cycle of ROM latency.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            vld_pipe <= '0;
        end else if (abort) begin
            vld_pipe <= '0;
        end else begin
            vld_pipe[0] <= issue;
            for (int i = 1; i < ROM_LAT; i++)
                vld_pipe[i] <= vld_pipe[i-1];
        end
    end

    // Index of the next returning pixel, used to tag the frame-end pixel.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)                      ret_idx <= '0;
        else if (abort || frame_start)  ret_idx <= '0;
        else if (vld_pipe[ROM_LAT-1])   ret_idx <= ret_idx + CNT_W'(1);
    end

    rgb_to_gray_pipe u_luma (
        .clk       (clk),
        .rstn      (rstn),
        .flush     (abort),
        .in_valid  (vld_pipe[ROM_LAT-1]),
        .in_last   (ret_idx == LAST_IDX),
        .in_r      (rgb_red),
        .in_g      (rgb_green),
        .in_b      (rgb_blue),
        .out_valid (gp_vld),
        .out_last  (gp_last),
        .out_gray  (gp_gray)
    );

    // FIFO storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (fifo_push) fifo_mem[wr_ptr] <= {gp_last, gp_gray};
    end

    // FIFO pointers and occupancy; abort flushes.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else if (abort) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (fifo_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (fifo_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({fifo_push, fifo_pop})
                2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
                2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

endmodule

// File: tb/tb_gray_frame_ctrl.sv
// Randomized bench for gray_frame_ctrl with a transaction-level reference model.
module tb_gray_frame_ctrl;

    localparam int H     = 3;
    localparam int W     = 4;
    localparam int N     = H * W;
    localparam int LAT   = 2;
    localparam int DEPTH = 4;
    localparam int AW    = 32;

    logic          clk = 1'b0;
    logic          rstn = 1'b1;
    logic          start = 1'b0, abort = 1'b0, pix_ready = 1'b0;
    logic          rom_en, pix_valid, pix_last, busy, done;
    logic [AW-1:0] rom_addr;
    logic [7:0]    rgb_red, rgb_green, rgb_blue, pix_data;

    always #5 clk = ~clk;

    gray_frame_ctrl #(.H(H), .W(W), .ROM_LAT(LAT), .FIFO_DEPTH(DEPTH), .ADDR_W(AW)) dut (
        .clk(clk), .rstn(rstn), .start(start), .abort(abort),
        .rom_en(rom_en), .rom_addr(rom_addr),
        .rgb_red(rgb_red), .rgb_green(rgb_green), .rgb_blue(rgb_blue),
        .pix_valid(pix_valid), .pix_data(pix_data), .pix_last(pix_last),
        .pix_ready(pix_ready), .busy(busy), .done(done)
    );

    // ROM model: image array, data appears LAT cycles after the strobe, junk otherwise.
    logic [23:0]          img [N];
    logic [LAT-1:0]       rp_vld = '0;
    logic [LAT-1:0][AW-1:0] rp_addr = '0;
    logic [23:0]          junk = '0;

    always @(posedge clk) begin
        rp_vld[0]  <= rom_en;
        rp_addr[0] <= rom_addr;
        for (int k = 1; k < LAT; k++) begin
            rp_vld[k]  <= rp_vld[k-1];
            rp_addr[k] <= rp_addr[k-1];
        end
        junk <= 24'($urandom);
    end

    always_comb begin
        {rgb_red, rgb_green, rgb_blue} = junk;
        if (rp_vld[LAT-1] && rp_addr[LAT-1] < AW'(N))
            {rgb_red, rgb_green, rgb_blue} = img[int'(rp_addr[LAT-1])];
    end

    int n_cmp = 0, n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, got, exp, $time);
        end
    endtask

    function automatic int gray_of(input logic [23:0] p);
        return (30 * int'(p[23:16]) + 59 * int'(p[15:8]) + 11 * int'(p[7:0])) / 128;
    endfunction

    // Reference model: frame progress counted in reads issued / pixels accepted.
    int         m_iss = 0, m_acc = 0, cyc = 0, dut_en_cnt = 0;
    bit         m_active = 0, m_done = 0;
    int         avail [N];
    logic [7:0] got_px [N];

    always @(negedge clk) begin
        bit ee, ev, fire, was;
        if (!rstn) begin
            chk("rst_rom_en", rom_en, 0);
            chk("rst_rom_addr", rom_addr, 0);
            chk("rst_pix_valid", pix_valid, 0);
            chk("rst_pix_last", pix_last, 0);
            chk("rst_busy", busy, 0);
            chk("rst_done", done, 0);
            m_active = 0; m_done = 0; m_iss = 0; m_acc = 0;
        end else begin
            ee = m_active && m_iss < N && (m_iss - m_acc) < DEPTH;
            ev = m_active && m_acc < m_iss && cyc >= avail[m_acc];
            chk("busy", busy, m_active);
            chk("done", done, m_done);
            chk("rom_en", rom_en, ee);
            chk("pix_valid", pix_valid, ev);
            if (ee) chk("rom_addr", rom_addr, m_iss);
            if (ev) begin
                chk("pix_data", pix_data, gray_of(img[m_acc]));
                chk("pix_last", pix_last, m_acc == N - 1);
            end
            if (rom_en) dut_en_cnt++;
            was = m_active;
            if (abort) begin
                m_active = 0; m_done = 0; m_iss = 0; m_acc = 0;
            end else begin
                fire = ev && pix_ready;
                if (fire) begin
                    got_px[m_acc] = pix_data;
                    m_acc++;
                    if (m_acc == N) begin m_active = 0; m_done = 1; end
                end
                if (ee) begin avail[m_iss] = cyc + LAT + 1; m_iss++; end
                if (start && !was) begin
                    m_active = 1; m_done = 0; m_iss = 0; m_acc = 0;
                end
            end
        end
        cyc++;
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic pulse_start();
        start = 1'b1; tick(); start = 1'b0;
    endtask

    task automatic rand_img();
        for (int i = 0; i < N; i++) img[i] = 24'($urandom);
    endtask

    task automatic wait_done(input int maxc, input bit rnd);
        for (int i = 0; i < maxc; i++) begin
            if (rnd) begin
                pix_ready = ($urandom_range(0, 3) != 0);
                start     = busy && ($urandom_range(0, 7) == 0);
            end
            tick();
            start = 1'b0;
            if (done) return;
        end
        chk("timeout_done", done, 1);
    endtask

    initial begin
        for (int i = 0; i < N; i++) img[i] = 24'hFFFFFF;
        chk("model_white", gray_of(img[0]), 199);
        #1 rstn = 1'b0;
        repeat (3) tick();
        rstn = 1'b1;
        tick();

        // White frame at full rate.
        pix_ready = 1'b1;
        pulse_start();
        wait_done(100, 0);
        chk("white_px0", got_px[0], 199);
        chk("white_pxN", got_px[N-1], 199);

        // Pure-channel pixels, started straight from DONE.
        rand_img();
        img[0] = 24'h640000; img[1] = 24'h006400; img[2] = 24'h000064;
        pulse_start();
        wait_done(100, 0);
        chk("red100", got_px[0], 23);
        chk("green100", got_px[1], 46);
        chk("blue100", got_px[2], 8);

        // Backpressure: credit stops reads at FIFO_DEPTH.
        rand_img();
        pix_ready = 1'b0;
        dut_en_cnt = 0;
        pulse_start();
        repeat (20) tick();
        chk("bp_reads", dut_en_cnt, DEPTH);
        chk("bp_rom_en_low", rom_en, 0);
        chk("bp_valid_held", pix_valid, 1);
        pix_ready = 1'b1;
        wait_done(100, 0);

        // Random ready with spurious starts while busy.
        repeat (3) begin
            rand_img();
            pulse_start();
            wait_done(400, 1);
        end

        // Abort after 5 accepted pixels, with start in the same cycle.
        rand_img();
        pulse_start();
        for (int i = 0; i < 200 && m_acc < 5; i++) begin
            pix_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        if (m_acc < 5) chk("timeout_abort", m_acc, 5);
        abort = 1'b1; start = 1'b1;
        tick();
        abort = 1'b0; start = 1'b0;
        chk("abort_valid", pix_valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        rand_img();
        pix_ready = 1'b1;
        pulse_start();
        wait_done(200, 1);

        // Start and abort together from DONE: abort wins.
        start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        chk("sa_busy", busy, 0);
        chk("sa_done", done, 0);
        tick();
        chk("sa_still_idle", busy, 0);

        // Asynchronous reset while draining.
        rand_img();
        pix_ready = 1'b1;
        pulse_start();
        for (int i = 0; i < 100 && !(m_iss == N && m_active); i++) tick();
        chk("drain_reached", busy && m_iss == N, 1);
        pix_ready = 1'b0;
        tick();
        #1 rstn = 1'b0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_valid", pix_valid, 0);
        chk("arst_rom_en", rom_en, 0);
        chk("arst_addr", rom_addr, 0);
        repeat (2) tick();
        rstn = 1'b1;
        tick();
        rand_img();
        pix_ready = 1'b1;
        pulse_start();
        wait_done(400, 1);
        repeat (3) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
